// File: rtl/legv8_pkg.sv
// Shared LEGv8 writeback definitions: load-size encodings, XZR index and the WB entry layout.
package legv8_pkg;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;
    localparam int OPC_W  = 11;

    localparam logic [1:0]        SZ_B    = 2'b00;
    localparam logic [1:0]        SZ_H    = 2'b01;
    localparam logic [1:0]        SZ_SW   = 2'b10;
    localparam logic [1:0]        SZ_D    = 2'b11;
    localparam logic [REG_AW-1:0] XZR_IDX = 5'd31;

    // One instruction as held in the MEM/WB register.
    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdata;
        logic              reg_write;
        logic              mem_to_reg;
        logic [1:0]        size;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-to-WB bundle plus the register-file write port; WB_RETIRE_CNT_EN adds retired_count.
interface writeback_stage_if;
    import legv8_pkg::*;

    logic              mem_valid;
    logic [OPC_W-1:0]  mem_opcode;
    logic [REG_AW-1:0] mem_dest_reg;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_reg_write;
    logic              mem_mem_to_reg;
    logic [1:0]        mem_size;
    logic              stall;
    logic              flush;

    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              RegWrite;
    logic              wb_valid;
    logic [OPC_W-1:0]  wb_opcode;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]       retired_count;
`endif

    modport master (
        output mem_valid, mem_opcode, mem_dest_reg, mem_alu_result, mem_read_data,
               mem_reg_write, mem_mem_to_reg, mem_size, stall, flush,
`ifdef WB_RETIRE_CNT_EN
        input  retired_count,
`endif
        input  write_reg, write_data, RegWrite, wb_valid, wb_opcode
    );

    modport slave (
        input  mem_valid, mem_opcode, mem_dest_reg, mem_alu_result, mem_read_data,
               mem_reg_write, mem_mem_to_reg, mem_size, stall, flush,
`ifdef WB_RETIRE_CNT_EN
        output retired_count,
`endif
        output write_reg, write_data, RegWrite, wb_valid, wb_opcode
    );

endinterface

// File: rtl/writeback_stage_load_extend.sv
// Load-size extension: B/H zero-extend, SW sign-extends the low word, D passes through.
module load_extend
    import legv8_pkg::*;
(
    input  logic [1:0]        i_size,
    input  logic [DATA_W-1:0] i_raw,
    output logic [DATA_W-1:0] o_val
);

    always_comb begin
        o_val = i_raw;
        case (i_size)
            SZ_B:    o_val = {56'd0, i_raw[7:0]};
            SZ_H:    o_val = {48'd0, i_raw[15:0]};
            SZ_SW:   o_val = {{32{i_raw[31]}}, i_raw[31:0]};
            default: o_val = i_raw;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register and writeback mux for the pipelined LEGv8 core.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
module writeback_stage
    import legv8_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input logic             clk,
    input logic             rst_n,
    writeback_stage_if.slave bus
);

    wb_entry_t         w_mem_entry;
    wb_entry_t         r_wb;
    logic              r_done;
    logic [DATA_W-1:0] w_load_val;
    logic [REG_AW-1:0] w_dest;
    logic              w_retire;

    assign w_mem_entry = '{
        valid:      bus.mem_valid & ~bus.flush,
        opcode:     bus.mem_opcode,
        dest:       bus.mem_dest_reg,
        alu:        bus.mem_alu_result,
        rdata:      bus.mem_read_data,
        reg_write:  bus.mem_reg_write,
        mem_to_reg: bus.mem_mem_to_reg,
        size:       bus.mem_size
    };

    // r_done marks a stalled entry that has already had its one write cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb   <= '0;
            r_done <= 1'b0;
        end else if (!bus.stall) begin
            r_wb   <= w_mem_entry;
            r_done <= 1'b0;
        end else if (bus.flush) begin
            r_wb.valid <= 1'b0;
            r_done     <= 1'b0;
        end else if (r_wb.valid) begin
            r_done <= 1'b1;
        end
    end

    load_extend u_load_extend (
        .i_size (r_wb.size),
        .i_raw  (r_wb.rdata),
        .o_val  (w_load_val)
    );

    assign w_dest   = r_wb.dest;
    assign w_retire = r_wb.valid & ~r_done;

    assign bus.write_reg  = w_dest;
    assign bus.write_data = r_wb.mem_to_reg ? w_load_val : r_wb.alu;
    assign bus.RegWrite   = w_retire & r_wb.reg_write & (w_dest != XZR_IDX);
    assign bus.wb_valid   = r_wb.valid;
    assign bus.wb_opcode  = r_wb.opcode;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retired;

    always_ff @(posedge clk) begin
        if (!rst_n)        r_retired <= 64'd0;
        else if (w_retire) r_retired <= r_retired + 64'd1;
    end

    assign bus.retired_count = r_retired;
`endif

endmodule
